// File: rtl/riscv_single_cycle.sv
// Single-cycle RV32I-subset core: every rising clk edge retires one instruction.
// Defining RISCV_MUL_EN adds the R-type MUL instruction (low 32 bits of rs1*rs2).
module riscv_imem #(
  parameter int WORDS = 256
) (
  input  logic                     clk,
  input  logic                     we,
  input  logic [$clog2(WORDS)-1:0] waddr,
  input  logic [31:0]              wdata,
  input  logic [$clog2(WORDS)-1:0] raddr,
  output logic [31:0]              rdata
);
  logic [31:0] memfile [WORDS];

  // The core never writes; the program image is preloaded from outside.
  always_ff @(posedge clk) begin
    if (we) memfile[waddr] <= wdata;
  end

  assign rdata = memfile[raddr];
endmodule

module riscv_single_cycle #(
  parameter int          IMEM_WORDS = 256,
  parameter int          DMEM_WORDS = 256,
  parameter logic [31:0] RESET_PC   = 32'h0000_0000
) (
  input logic clk,
  input logic rst
);
  localparam int IAW = $clog2(IMEM_WORDS);
  localparam int DAW = $clog2(DMEM_WORDS);

  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_REG    = 7'b0110011;

  logic [31:0] pc_reg, pc_next, pc_plus4, instr;
  logic [31:0] rf_reg [32];
  logic [31:0] dmem_reg [DMEM_WORDS];

  logic [6:0]  opcode, funct7;
  logic [2:0]  funct3;
  logic [4:0]  rs1, rs2, rd;
  logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j;
  logic [31:0] rs1_val, rs2_val, load_data;
  logic [DAW-1:0] ld_idx, st_idx;
  logic        br_taken, imm_legal, reg_legal;
  logic        wb_en, st_en;
  logic [31:0] wb_data;

  riscv_imem #(.WORDS(IMEM_WORDS)) uutA (
    .clk   (clk),
    .we    (1'b0),
    .waddr ('0),
    .wdata ('0),
    .raddr (IAW'(pc_reg >> 2)),
    .rdata (instr)
  );

  assign opcode = instr[6:0];
  assign rd     = instr[11:7];
  assign funct3 = instr[14:12];
  assign rs1    = instr[19:15];
  assign rs2    = instr[24:20];
  assign funct7 = instr[31:25];

  assign imm_i = {{20{instr[31]}}, instr[31:20]};
  assign imm_s = {{20{instr[31]}}, instr[31:25], instr[11:7]};
  assign imm_b = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
  assign imm_u = {instr[31:12], 12'b0};
  assign imm_j = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};

  // x0 is forced to zero on read so it is correct even before the first reset.
  assign rs1_val   = (rs1 == 5'd0) ? 32'd0 : rf_reg[rs1];
  assign rs2_val   = (rs2 == 5'd0) ? 32'd0 : rf_reg[rs2];
  assign pc_plus4  = pc_reg + 32'd4;
  assign ld_idx    = DAW'((rs1_val + imm_i) >> 2);
  assign st_idx    = DAW'((rs1_val + imm_s) >> 2);
  assign load_data = dmem_reg[ld_idx];

  assign imm_legal = (funct3 == 3'b001) ? (funct7 == 7'h00) :
                     (funct3 == 3'b101) ? (funct7 == 7'h00 || funct7 == 7'h20) : 1'b1;
  assign reg_legal = (funct7 == 7'h00) ||
                     (funct7 == 7'h20 && (funct3 == 3'b000 || funct3 == 3'b101));

  function automatic logic [31:0] alu(input logic [2:0] f3, input logic alt,
                                      input logic [31:0] a, input logic [31:0] b);
    case (f3)
      3'b000:  alu = alt ? a - b : a + b;
      3'b001:  alu = a << b[4:0];
      3'b010:  alu = {31'b0, $signed(a) < $signed(b)};
      3'b011:  alu = {31'b0, a < b};
      3'b100:  alu = a ^ b;
      3'b101:  alu = alt ? $unsigned($signed(a) >>> b[4:0]) : a >> b[4:0];
      3'b110:  alu = a | b;
      default: alu = a & b;
    endcase
  endfunction

  always_comb begin
    case (funct3)
      3'b000:  br_taken = (rs1_val == rs2_val);
      3'b001:  br_taken = (rs1_val != rs2_val);
      3'b100:  br_taken = ($signed(rs1_val) <  $signed(rs2_val));
      3'b101:  br_taken = ($signed(rs1_val) >= $signed(rs2_val));
      3'b110:  br_taken = (rs1_val <  rs2_val);
      3'b111:  br_taken = (rs1_val >= rs2_val);
      default: br_taken = 1'b0;
    endcase
  end

  // Anything not matched below (including unloaded or X words) falls through as a NOP.
  always_comb begin
    pc_next = pc_plus4;
    wb_en   = 1'b0;
    wb_data = '0;
    st_en   = 1'b0;
    case (opcode)
      OP_LUI:   begin wb_en = 1'b1; wb_data = imm_u; end
      OP_AUIPC: begin wb_en = 1'b1; wb_data = pc_reg + imm_u; end
      OP_JAL:   begin wb_en = 1'b1; wb_data = pc_plus4; pc_next = pc_reg + imm_j; end
      OP_JALR: begin
        if (funct3 == 3'b000) begin
          wb_en   = 1'b1;
          wb_data = pc_plus4;
          pc_next = (rs1_val + imm_i) & ~32'd1;
        end
      end
      OP_BRANCH: if (br_taken) pc_next = pc_reg + imm_b;
      OP_LOAD:   if (funct3 == 3'b010) begin wb_en = 1'b1; wb_data = load_data; end
      OP_STORE:  st_en = (funct3 == 3'b010);
      OP_IMM: begin
        wb_en   = imm_legal;
        wb_data = alu(funct3, (funct3 == 3'b101) & instr[30], rs1_val, imm_i);
      end
      OP_REG: begin
        if (reg_legal) begin
          wb_en   = 1'b1;
          wb_data = alu(funct3, instr[30], rs1_val, rs2_val);
        end
`ifdef RISCV_MUL_EN
        else if (funct7 == 7'h01 && funct3 == 3'b000) begin
          wb_en   = 1'b1;
          wb_data = rs1_val * rs2_val;
        end
`endif
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc_reg <= RESET_PC;
      for (int i = 0; i < 32; i++) rf_reg[i] <= '0;
    end else begin
      pc_reg <= pc_next;
      if (wb_en && rd != 5'd0) rf_reg[rd] <= wb_data;
    end
  end

  // Data memory has no reset so it can map onto block RAM; reset only blocks the store.
  always_ff @(posedge clk) begin
    if (st_en && !rst) dmem_reg[st_idx] <= rs2_val;
  end
endmodule

// File: tb/tb_riscv_single_cycle.sv
// Scoreboard bench for riscv_single_cycle: an instruction-level model predicts the
// architectural state after every edge; a monitor compares it against the core.
module tb_riscv_single_cycle;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  riscv_single_cycle core (.clk(clk), .rst(rst));

  localparam int K_STATE = 0, K_PC = 1, K_REG = 2, K_MEM = 3;

  typedef struct {
    int                kind;
    int                idx;
    logic [31:0]       val;
    logic [31:0]       pc;
    logic [31:0][31:0] rf;
    logic [31:0]       mh;
  } sb_item_t;

  sb_item_t    sb[$];
  int          n_checks = 0;
  int          n_pass = 0;
  int          n_edges = 0;
  logic [31:0] prog [256];
  logic [31:0] m_pc;
  logic [31:0] m_rf [32];
  logic [31:0] m_mem [256];

  // ---------------- instruction encoders ----------------
  function automatic logic [31:0] enc_i(int imm, int rs1, int f3, int rd, int op);
    logic [31:0] v; v = imm;
    return {v[11:0], 5'(rs1), 3'(f3), 5'(rd), 7'(op)};
  endfunction
  function automatic logic [31:0] enc_s(int imm, int rs2, int rs1, int f3);
    logic [31:0] v; v = imm;
    return {v[11:5], 5'(rs2), 5'(rs1), 3'(f3), v[4:0], 7'h23};
  endfunction
  function automatic logic [31:0] enc_b(int imm, int rs2, int rs1, int f3);
    logic [31:0] v; v = imm;
    return {v[12], v[10:5], 5'(rs2), 5'(rs1), 3'(f3), v[4:1], v[11], 7'h63};
  endfunction
  function automatic logic [31:0] enc_u(int imm20, int rd, int op);
    logic [31:0] v; v = imm20;
    return {v[19:0], 5'(rd), 7'(op)};
  endfunction
  function automatic logic [31:0] enc_j(int imm, int rd);
    logic [31:0] v; v = imm;
    return {v[20], v[10:1], v[11], v[19:12], 5'(rd), 7'h6f};
  endfunction
  function automatic logic [31:0] enc_r(int f7, int rs2, int rs1, int f3, int rd);
    return {7'(f7), 5'(rs2), 5'(rs1), 3'(f3), 5'(rd), 7'h33};
  endfunction
  function automatic logic [31:0] addi(int rd, int rs1, int imm);
    return enc_i(imm, rs1, 0, rd, 'h13);
  endfunction

  // ---------------- reference model ----------------
  function automatic logic [31:0] sx(logic [31:0] v, int bits);
    return $unsigned($signed(v << (32 - bits)) >>> (32 - bits));
  endfunction

  function automatic logic [31:0] mem_hash(input logic [31:0] m [256]);
    logic [31:0] h = 32'h1505;
    for (int i = 0; i < 256; i++) h = ((h << 5) + h) ^ (m[i] + i);
    return h;
  endfunction

  task automatic model_step(input bit r);
    logic [31:0] ins, a, b, nxt, res, ii, is, ib, ij, ea;
    logic [6:0]  op, f7;
    logic [2:0]  f3;
    logic [4:0]  sh;
    bit          wr, tk;
    if (r) begin
      m_pc = 32'h0;
      for (int i = 0; i < 32; i++) m_rf[i] = 32'h0;
      return;
    end
    ins = prog[m_pc[9:2]];
    op = ins[6:0]; f3 = ins[14:12]; f7 = ins[31:25];
    a = m_rf[ins[19:15]]; b = m_rf[ins[24:20]];
    ii = sx(ins >> 20, 12);
    is = sx(((ins >> 25) << 5) | ((ins >> 7) & 32'd31), 12);
    ib = sx((((ins >> 31) & 1) << 12) | (((ins >> 7) & 1) << 11) |
            (((ins >> 25) & 63) << 5) | (((ins >> 8) & 15) << 1), 13);
    ij = sx((((ins >> 31) & 1) << 20) | (((ins >> 12) & 255) << 12) |
            (((ins >> 20) & 1) << 11) | (((ins >> 21) & 1023) << 1), 21);
    nxt = m_pc + 4; wr = 0; res = 0; tk = 0;
    case (op)
      7'h37: begin wr = 1; res = ins & 32'hFFFF_F000; end
      7'h17: begin wr = 1; res = m_pc + (ins & 32'hFFFF_F000); end
      7'h6f: begin wr = 1; res = m_pc + 4; nxt = m_pc + ij; end
      7'h67: if (f3 == 0) begin wr = 1; res = m_pc + 4; nxt = (a + ii) & 32'hFFFF_FFFE; end
      7'h63: begin
        case (f3)
          0: tk = (a == b);
          1: tk = (a != b);
          4: tk = ($signed(a) < $signed(b));
          5: tk = !($signed(a) < $signed(b));
          6: tk = (a < b);
          7: tk = !(a < b);
          default: tk = 0;
        endcase
        if (tk) nxt = m_pc + ib;
      end
      7'h03: if (f3 == 2) begin ea = a + ii; wr = 1; res = m_mem[ea[9:2]]; end
      7'h23: if (f3 == 2) begin ea = a + is; m_mem[ea[9:2]] = b; end
      7'h13: begin
        sh = ii[4:0]; wr = 1;
        case (f3)
          0: res = a + ii;
          2: res = ($signed(a) < $signed(ii)) ? 1 : 0;
          3: res = (a < ii) ? 1 : 0;
          4: res = a ^ ii;
          6: res = a | ii;
          7: res = a & ii;
          1: begin wr = (f7 == 0); res = a << sh; end
          default: begin
            wr = (f7 == 0) || (f7 == 7'h20);
            res = (f7 == 7'h20) ? $unsigned($signed(a) >>> sh) : a >> sh;
          end
        endcase
      end
      7'h33: begin
        sh = b[4:0];
        if (f7 == 0) begin
          wr = 1;
          case (f3)
            0: res = a + b;
            1: res = a << sh;
            2: res = ($signed(a) < $signed(b)) ? 1 : 0;
            3: res = (a < b) ? 1 : 0;
            4: res = a ^ b;
            5: res = a >> sh;
            6: res = a | b;
            default: res = a & b;
          endcase
        end else if (f7 == 7'h20 && f3 == 0) begin wr = 1; res = a - b; end
        else if (f7 == 7'h20 && f3 == 5) begin wr = 1; res = $unsigned($signed(a) >>> sh); end
`ifdef RISCV_MUL_EN
        else if (f7 == 7'h01 && f3 == 0) begin wr = 1; res = a * b; end
`endif
      end
      default: ;
    endcase
    if (wr && ins[11:7] != 0) m_rf[ins[11:7]] = res;
    m_pc = nxt;
  endtask

  // ---------------- stimulus side ----------------
  task automatic cycle(input bit r);
    sb_item_t it;
    @(negedge clk);
    rst = r;
    model_step(r);
    it.kind = K_STATE; it.idx = 0; it.val = 0; it.pc = m_pc;
    for (int i = 0; i < 32; i++) it.rf[i] = m_rf[i];
    it.mh = mem_hash(m_mem);
    sb.push_back(it);
  endtask

  task automatic spot(input int kind, input int idx, input logic [31:0] v);
    sb_item_t it;
    it.kind = kind; it.idx = idx; it.val = v; it.pc = 0; it.rf = '0; it.mh = 0;
    sb.push_back(it);
  endtask

  task automatic clear_prog();
    for (int i = 0; i < 256; i++) prog[i] = 32'h0;
  endtask

  // Load the image while reset is held; the edge in between is not checked.
  task automatic commit_prog();
    @(negedge clk);
    rst = 1'b1;
    for (int i = 0; i < 256; i++) core.uutA.memfile[i] = prog[i];
    cycle(1'b1);
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) cycle(1'b0);
  endtask

  function automatic logic [31:0] rnd_instr();
    int rd, rs1, rs2, f3, f7, n, imm;
    int f7_tab[5] = '{0, 0, 'h20, 1, 2};
    rd = $urandom_range(0, 7); rs1 = $urandom_range(0, 7); rs2 = $urandom_range(0, 7);
    f3 = $urandom_range(0, 7); imm = $urandom;
    n = $urandom_range(1, 8) * 4;
    if ($urandom_range(0, 1) == 1) n = -n;
    case ($urandom_range(0, 12))
      0:  return enc_u(imm, rd, 'h37);
      1:  return enc_u(imm, rd, 'h17);
      2:  return enc_i((f7_tab[$urandom_range(0, 4)] << 5) | (imm & 31), rs1, f3, rd, 'h13);
      3, 4: return enc_r(f7_tab[$urandom_range(0, 4)], rs2, rs1, f3, rd);
      5:  return enc_b(n, rs2, rs1, f3);
      6:  return enc_j(n, rd);
      7:  return enc_i(imm & 63, rs1, ($urandom_range(0, 3) == 0) ? f3 : 0, rd, 'h67);
      8:  return enc_i(imm, rs1, ($urandom_range(0, 3) == 0) ? f3 : 2, rd, 'h03);
      9:  return enc_s(imm, rs2, rs1, ($urandom_range(0, 3) == 0) ? f3 : 2);
      10: return $urandom;
      11: return addi(rd, rs1, imm);
      default: return ($urandom_range(0, 1) == 1) ? 32'h0000_000f : 32'h0000_0073;
    endcase
  endfunction

  initial begin
    for (int i = 0; i < 256; i++) begin m_mem[i] = 0; core.dmem_reg[i] = 0; end
    for (int i = 0; i < 32; i++) m_rf[i] = 0;
    m_pc = 0;

    // Reset, then ALU program
    clear_prog();
    prog[0] = addi(1, 0, 5);
    prog[1] = addi(2, 0, -3);
    prog[2] = enc_r(0, 2, 1, 0, 3);
    prog[3] = enc_r('h20, 2, 1, 0, 4);
    prog[4] = enc_r(0, 1, 2, 2, 5);
    prog[5] = enc_r(0, 1, 2, 3, 6);
    prog[6] = enc_i('h401, 2, 5, 7, 'h13);
    prog[7] = addi(0, 0, 7);
    prog[8] = enc_j(0, 0);
    commit_prog();
    spot(K_PC, 0, 32'h0);
    cycle(1'b1);
    spot(K_PC, 0, 32'h0); spot(K_REG, 1, 0); spot(K_REG, 31, 0);
    cycle(1'b0); spot(K_PC, 0, 32'h4);
    cycle(1'b0); spot(K_PC, 0, 32'h8);
    run(8);
    spot(K_REG, 3, 32'd2); spot(K_REG, 4, 32'd8); spot(K_REG, 5, 32'd1);
    spot(K_REG, 6, 32'd0); spot(K_REG, 7, 32'hFFFF_FFFE); spot(K_REG, 0, 32'd0);
    spot(K_PC, 0, 32'h20);

    // Store then load
    clear_prog();
    prog[0] = addi(1, 0, 'h40);
    prog[1] = addi(2, 0, 123);
    prog[2] = enc_s(4, 2, 1, 2);
    prog[3] = enc_i(4, 1, 2, 3, 'h03);
    prog[4] = enc_j(0, 0);
    commit_prog();
    run(6);
    spot(K_MEM, 17, 32'd123); spot(K_REG, 3, 32'd123);

    // Branches and jumps
    clear_prog();
    prog[0] = addi(1, 0, 1);
    prog[1] = addi(2, 0, 1);
    prog[2] = enc_b(8, 2, 1, 0);
    prog[3] = addi(3, 0, 9);
    prog[4] = enc_j(8, 1);
    prog[5] = enc_j(16, 0);
    prog[6] = enc_b(8, 1, 1, 1);
    prog[7] = addi(4, 0, 3);
    prog[8] = enc_i(0, 1, 0, 0, 'h67);
    prog[9] = enc_j(0, 0);
    commit_prog();
    run(4); spot(K_PC, 0, 32'h18); spot(K_REG, 1, 32'h14);
    run(3); spot(K_PC, 0, 32'h14);
    run(3);
    spot(K_PC, 0, 32'h24); spot(K_REG, 3, 32'd0); spot(K_REG, 4, 32'd3);

    // Upper immediates
    clear_prog();
    prog[0] = enc_u('h12345, 1, 'h37);
    prog[1] = addi(0, 0, 0);
    prog[2] = enc_u(1, 2, 'h17);
    prog[3] = enc_j(0, 0);
    commit_prog();
    run(5);
    spot(K_REG, 1, 32'h1234_5000); spot(K_REG, 2, 32'h0000_1008);

    // Reset in the middle of a loop
    clear_prog();
    prog[0] = addi(1, 1, 1);
    prog[1] = enc_j(-4, 0);
    commit_prog();
    run(6); spot(K_REG, 1, 32'd3);
    cycle(1'b1); spot(K_PC, 0, 32'h0); spot(K_REG, 1, 32'd0);
    run(1); spot(K_REG, 1, 32'd1);

    // Reset on a store cycle must suppress the store
    clear_prog();
    prog[0] = addi(1, 0, 77);
    prog[1] = enc_s(8, 1, 0, 2);
    prog[2] = enc_j(0, 0);
    commit_prog();
    run(1);
    cycle(1'b1); spot(K_MEM, 2, 32'd0); spot(K_PC, 0, 32'h0);
    run(3); spot(K_MEM, 2, 32'd77);

    // MUL encoding
    clear_prog();
    prog[0] = addi(1, 0, 6);
    prog[1] = addi(2, 0, 7);
    prog[2] = addi(3, 0, 5);
    prog[3] = enc_r(1, 2, 1, 0, 3);
    prog[4] = enc_j(0, 0);
    commit_prog();
    run(6);
`ifdef RISCV_MUL_EN
    spot(K_REG, 3, 32'd42);
`else
    spot(K_REG, 3, 32'd5);
`endif

    // Random programs with occasional resets
    for (int p = 0; p < 4; p++) begin
      clear_prog();
      for (int i = 0; i < 48; i++) prog[i] = rnd_instr();
      commit_prog();
      for (int c = 0; c < 150; c++) cycle($urandom_range(0, 49) == 0);
    end

    @(negedge clk);
    @(negedge clk);
    n_checks++;
    if (sb.size() == 0) n_pass++;
    else $display("FAIL scoreboard_drain: %0d items left, expected 0", sb.size());
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  // ---------------- monitor side ----------------
  task automatic cmp(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %08h expected %08h", nm, got, exp);
  endtask

  task automatic check_item(input sb_item_t it);
    logic [31:0] dm [256];
    int bad;
    case (it.kind)
      K_STATE: begin
        n_edges++;
        $display("edge %0d: pc=%08h rst=%0b", n_edges, core.pc_reg, rst);
        cmp("pc", core.pc_reg, it.pc);
        bad = -1;
        for (int j = 0; j < 32; j++)
          if (bad < 0 && core.rf_reg[j] !== it.rf[j]) bad = j;
        n_checks++;
        if (bad < 0) n_pass++;
        else $display("FAIL regs: x%0d got %08h expected %08h", bad, core.rf_reg[bad], it.rf[bad]);
        for (int j = 0; j < 256; j++) dm[j] = core.dmem_reg[j];
        cmp("dmem_hash", mem_hash(dm), it.mh);
      end
      K_PC:  cmp("spot_pc", core.pc_reg, it.val);
      K_REG: cmp($sformatf("spot_x%0d", it.idx), core.rf_reg[it.idx], it.val);
      default: cmp($sformatf("spot_dmem[%0d]", it.idx), core.dmem_reg[it.idx], it.val);
    endcase
  endtask

  always @(posedge clk) begin
    #1;
    while (sb.size() != 0) check_item(sb.pop_front());
  end
endmodule
